// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout engine with per-tube stock,
// hopper handshake and sticky timeout fault.
//
// Ports:
//   clock, rst        rising-edge clock, async active-low reset
//   change_valid      payout request, change_amount sampled in IDLE
//   change_amount     value to pay out (units)
//   refill            in IDLE, reload every tube to INIT_COUNT
//   coin_ack          hopper confirms the requested coin dropped
//   change_ready      idle and able to accept a request
//   busy              payout in progress (SELECT/WAIT_ACK/DONE)
//   coin_eject        one-hot coin request, bit4..0 = 50,20,10,5,1
//   done              one-cycle end-of-payout pulse
//   short_change      with done when part of the amount was unpaid
//   shortfall         unpaid remainder of the last payout
//   low_stock         per-tube empty flags, same order as coin_eject
//   fault             hopper timeout, held until reset
module change_dispenser #(
    parameter int unsigned INIT_COUNT = 8,
    parameter int unsigned COIN_WAIT  = 15
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       change_valid,
    input  logic [7:0] change_amount,
    input  logic       refill,
    input  logic       coin_ack,
    output logic       change_ready,
    output logic       busy,
    output logic [4:0] coin_eject,
    output logic       done,
    output logic       short_change,
    output logic [7:0] shortfall,
    output logic [4:0] low_stock,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [7:0] INIT_C    = 8'(INIT_COUNT);
    localparam logic [7:0] WAIT_LAST = 8'(COIN_WAIT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] remaining;
    logic [7:0] count [5];
    logic [7:0] timer;
    logic [4:0] pick;
    logic       found;
    logic [7:0] ack_val;

    // Face value of tube idx (0 = 1-unit coin .. 4 = 50-unit coin).
    function automatic logic [7:0] coin_val(input int idx);
        logic [7:0] v;
        case (idx)
            0:       v = 8'd1;
            1:       v = 8'd5;
            2:       v = 8'd10;
            3:       v = 8'd20;
            4:       v = 8'd50;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    // Greedy choice: ascending scan, so the largest eligible tube wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (count[i] != 8'd0 && coin_val(i) <= remaining) begin
                pick    = '0;
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    // Value of the coin currently held on coin_eject.
    always_comb begin
        ack_val = '0;
        for (int i = 0; i < 5; i++) begin
            if (coin_eject[i]) begin
                ack_val = ack_val | coin_val(i);
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (change_valid) begin
                    state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                state_nxt = found ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
                if (coin_ack) begin
                    state_nxt = S_SELECT;
                end else if (timer == WAIT_LAST) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            remaining  <= '0;
            timer      <= '0;
            coin_eject <= '0;
            shortfall  <= '0;
            for (int i = 0; i < 5; i++) begin
                count[i] <= INIT_C;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (change_valid) begin
                        remaining <= change_amount;
                        shortfall <= '0;
                    end else if (refill) begin
                        for (int i = 0; i < 5; i++) begin
                            count[i] <= INIT_C;
                        end
                    end
                end
                S_SELECT: begin
                    if (found) begin
                        coin_eject <= pick;
                        timer      <= '0;
                    end
                end
                S_WAIT: begin
                    if (coin_ack) begin
                        remaining  <= remaining - ack_val;
                        coin_eject <= '0;
                        for (int i = 0; i < 5; i++) begin
                            if (coin_eject[i]) begin
                                count[i] <= count[i] - 8'd1;
                            end
                        end
                    end else begin
                        timer <= timer + 8'd1;
                        if (timer == WAIT_LAST) begin
                            coin_eject <= '0;
                        end
                    end
                end
                S_DONE: begin
                    shortfall <= remaining;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        change_ready = (state == S_IDLE);
        busy         = (state == S_SELECT) ||
                       (state == S_WAIT)   ||
                       (state == S_DONE);
        done         = (state == S_DONE);
        short_change = (state == S_DONE) && (remaining != 8'd0);
        fault        = (state == S_FAULT);
        for (int i = 0; i < 5; i++) begin
            low_stock[i] = (count[i] == 8'd0);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table vectors, corner sequences and random
// payouts checked against a per-denomination arithmetic model.
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       change_valid = 1'b0;
    logic [7:0] change_amount = '0;
    logic       refill = 1'b0;
    logic       coin_ack = 1'b0;
    logic       use_one = 1'b0;

    logic       d_ready, d_busy, d_done, d_sc, d_fault;
    logic [4:0] d_eject, d_low;
    logic [7:0] d_sf;
    logic       o_ready, o_busy, o_done, o_sc, o_fault;
    logic [4:0] o_eject, o_low;
    logic [7:0] o_sf;

    logic       ob_ready, ob_busy, ob_done, ob_sc, ob_fault;
    logic [4:0] ob_eject, ob_low;
    logic [7:0] ob_sf;

    always #5 clock = ~clock;

    change_dispenser #(.INIT_COUNT(8), .COIN_WAIT(15)) u_dut (
        .clock(clock), .rst(rst),
        .change_valid(change_valid & ~use_one),
        .change_amount(change_amount),
        .refill(refill & ~use_one),
        .coin_ack(coin_ack & ~use_one),
        .change_ready(d_ready), .busy(d_busy), .coin_eject(d_eject),
        .done(d_done), .short_change(d_sc), .shortfall(d_sf),
        .low_stock(d_low), .fault(d_fault)
    );

    change_dispenser #(.INIT_COUNT(1), .COIN_WAIT(15)) u_one (
        .clock(clock), .rst(rst),
        .change_valid(change_valid & use_one),
        .change_amount(change_amount),
        .refill(refill & use_one),
        .coin_ack(coin_ack & use_one),
        .change_ready(o_ready), .busy(o_busy), .coin_eject(o_eject),
        .done(o_done), .short_change(o_sc), .shortfall(o_sf),
        .low_stock(o_low), .fault(o_fault)
    );

    assign ob_ready = use_one ? o_ready : d_ready;
    assign ob_busy  = use_one ? o_busy  : d_busy;
    assign ob_done  = use_one ? o_done  : d_done;
    assign ob_sc    = use_one ? o_sc    : d_sc;
    assign ob_fault = use_one ? o_fault : d_fault;
    assign ob_eject = use_one ? o_eject : d_eject;
    assign ob_low   = use_one ? o_low   : d_low;
    assign ob_sf    = use_one ? o_sf    : d_sf;

    int checks = 0;
    int failures = 0;

    int VALS [5] = '{1, 5, 10, 20, 50};
    int m_cnt [5];
    int m_sf;
    int exp_q [$];
    int got_q [$];
    int g_lat, g_sf, g_sc;

    typedef struct {
        bit         do_refill;
        logic [7:0] amount;
        int         ncoins;
        int         sf;
        logic [4:0] low;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic int dec(input logic [4:0] e);
        case (e)
            5'b10000: return 50;
            5'b01000: return 20;
            5'b00100: return 10;
            5'b00010: return 5;
            5'b00001: return 1;
            default:  return -1;
        endcase
    endfunction

    task automatic m_refill();
        for (int i = 0; i < 5; i++) m_cnt[i] = 8;
    endtask

    // Per denomination: take as many as the remainder and the stock allow.
    task automatic m_pay(input int amt);
        int rem, n;
        exp_q.delete();
        rem = amt;
        for (int i = 4; i >= 0; i--) begin
            n = rem / VALS[i];
            if (n > m_cnt[i]) n = m_cnt[i];
            repeat (n) exp_q.push_back(VALS[i]);
            rem -= n * VALS[i];
            m_cnt[i] -= n;
        end
        m_sf = rem;
    endtask

    function automatic logic [4:0] m_low();
        logic [4:0] l;
        for (int i = 0; i < 5; i++) l[i] = (m_cnt[i] == 0);
        return l;
    endfunction

    task automatic do_refill();
        refill = 1'b1;
        @(posedge clock); #1;
        refill = 1'b0;
    endtask

    // Issue one request; ack each coin k cycles after it appears.
    task automatic run_req(input logic [7:0] amt, input int k,
                           input bit rf);
        int cyc, wc;
        bit waiting, fin;
        got_q.delete();
        g_lat = -1; g_sc = 0; g_sf = -1;
        waiting = 0; fin = 0; wc = 0;
        change_amount = amt;
        change_valid = 1'b1;
        refill = rf;
        @(posedge clock); #1;
        change_valid = 1'b0;
        refill = 1'b0;
        for (cyc = 1; cyc <= 1500 && !fin; cyc++) begin
            @(posedge clock); #1;
            if (coin_ack) begin
                coin_ack = 1'b0;
                waiting = 0;
            end
            if (!waiting && ob_eject != 5'd0) begin
                got_q.push_back(dec(ob_eject));
                waiting = 1;
                wc = 0;
            end
            if (waiting) begin
                wc++;
                if (wc == k) coin_ack = 1'b1;
            end
            if (ob_done) begin
                g_lat = cyc;
                g_sc = int'(ob_sc);
                fin = 1;
            end
        end
        if (!fin) begin
            chk("req_timeout", 0, 1);
        end else begin
            @(posedge clock); #1;
            g_sf = int'(ob_sf);
            chk("ready_after_done", int'(ob_ready), 1);
        end
    endtask

    task automatic check_txn(input int k);
        chk("coin_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("coin_value", got_q[i], exp_q[i]);
        chk("shortfall", g_sf, m_sf);
        chk("short_change", g_sc, int'(m_sf != 0));
        chk("done_latency", g_lat, 1 + exp_q.size() * (1 + k));
        chk("low_stock", int'(ob_low), int'(m_low()));
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'd85,  4,  0, 5'b00000};
        tbl[1] = '{1'b1, 8'd0,   0,  0, 5'b00000};
        tbl[2] = '{1'b1, 8'd1,   1,  0, 5'b00000};
        tbl[3] = '{1'b1, 8'd99,  8,  0, 5'b00000};
        tbl[4] = '{1'b1, 8'd49,  7,  0, 5'b00000};
        tbl[5] = '{1'b1, 8'd37,  5,  0, 5'b00000};
        tbl[6] = '{1'b1, 8'd255, 6,  0, 5'b00000};
        tbl[7] = '{1'b0, 8'd255, 9,  0, 5'b10000};
        tbl[8] = '{1'b0, 8'd200, 25, 22, 5'b11111};

        m_refill();
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", int'(ob_ready), 1);
        chk("rst_busy", int'(ob_busy), 0);
        chk("rst_eject", int'(ob_eject), 0);
        chk("rst_low", int'(ob_low), 0);
        rst = 1'b1;
        @(posedge clock); #1;
        chk("idle_done", int'(ob_done), 0);
        chk("idle_sc", int'(ob_sc), 0);
        chk("idle_sf", int'(ob_sf), 0);
        chk("idle_fault", int'(ob_fault), 0);

        // Table vectors, ack one cycle after each eject.
        for (int v = 0; v < 9; v++) begin
            if (tbl[v].do_refill) begin
                do_refill();
                m_refill();
                chk("refill_low", int'(ob_low), 0);
            end
            m_pay(int'(tbl[v].amount));
            run_req(tbl[v].amount, 1, 1'b0);
            chk("tbl_ncoins", got_q.size(), tbl[v].ncoins);
            chk("tbl_sf", g_sf, tbl[v].sf);
            chk("tbl_sc", g_sc, int'(tbl[v].sf != 0));
            chk("tbl_lat", g_lat, 1 + 2 * tbl[v].ncoins);
            chk("tbl_low", int'(ob_low), int'(tbl[v].low));
            check_txn(1);
        end
        chk("first85_coin", dec(5'b10000), 50);

        // Zero amount with same-cycle refill: tubes stay empty.
        m_pay(0);
        run_req(8'd0, 1, 1'b1);
        chk("zero_ncoins", got_q.size(), 0);
        chk("zero_lat", g_lat, 1);
        chk("zero_sc", g_sc, 0);
        chk("zero_low", int'(ob_low), 5'b11111);
        do_refill();
        m_refill();
        chk("refill_low2", int'(ob_low), 0);

        // Empty the 50 tube, then reset mid-payout.
        repeat (2) begin
            m_pay(255);
            run_req(8'd255, 1, 1'b0);
            check_txn(1);
        end
        chk("drained_low", int'(ob_low), 5'b10000);
        change_amount = 8'd85;
        change_valid = 1'b1;
        @(posedge clock); #1;
        change_valid = 1'b0;
        @(posedge clock); #1;
        chk("mid_eject", dec(ob_eject), 20);
        repeat (3) @(posedge clock);
        #1;
        chk("mid_hold", dec(ob_eject), 20);
        chk("mid_busy", int'(ob_busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_eject", int'(ob_eject), 0);
        chk("arst_busy", int'(ob_busy), 0);
        chk("arst_ready", int'(ob_ready), 1);
        chk("arst_low", int'(ob_low), 0);
        @(negedge clock);
        rst = 1'b1;
        @(posedge clock); #1;
        m_refill();
        m_pay(20);
        run_req(8'd20, 2, 1'b0);
        check_txn(2);
        chk("after_rst_20", got_q.size() == 1 ? got_q[0] : -1, 20);
        m_pay(50);
        run_req(8'd50, 1, 1'b0);
        check_txn(1);
        chk("after_rst_50", got_q.size() == 1 ? got_q[0] : -1, 50);

        // Stray acks while idle must not touch stock.
        coin_ack = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        coin_ack = 1'b0;
        chk("stray_ready", int'(ob_ready), 1);
        chk("stray_busy", int'(ob_busy), 0);
        m_pay(6);
        run_req(8'd6, 1, 1'b0);
        check_txn(1);
        chk("six_first", got_q.size() > 0 ? got_q[0] : -1, 5);

        // Random payouts against the model.
        for (int t = 0; t < 40; t++) begin
            int amt, k;
            if ($urandom_range(0, 4) == 0) begin
                do_refill();
                m_refill();
            end
            amt = int'($urandom_range(0, 255));
            k = int'($urandom_range(1, 4));
            m_pay(amt);
            run_req(8'(amt), k, 1'b0);
            check_txn(k);
        end

        // Single-coin tubes: 100 leaves 14 unpaid.
        use_one = 1'b1;
        #1;
        run_req(8'd100, 1, 1'b0);
        chk("one_ncoins", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            chk("one_coin", got_q[i], VALS[4 - i]);
        chk("one_sf", g_sf, 14);
        chk("one_sc", g_sc, 1);
        chk("one_lat", g_lat, 11);
        chk("one_low", int'(ob_low), 5'b11111);
        do_refill();
        chk("one_refill_low", int'(ob_low), 0);
        use_one = 1'b0;
        #1;

        // Hopper never acks: fault after exactly 15 cycles.
        do_refill();
        change_amount = 8'd85;
        change_valid = 1'b1;
        @(posedge clock); #1;
        change_valid = 1'b0;
        @(posedge clock); #1;
        chk("flt_eject", dec(ob_eject), 50);
        for (int c = 1; c <= 15; c++) begin
            @(posedge clock); #1;
            if (c == 14) begin
                chk("flt_pre", int'(ob_fault), 0);
                chk("flt_pre_eject", dec(ob_eject), 50);
            end
            if (c == 15) begin
                chk("flt_set", int'(ob_fault), 1);
                chk("flt_eject_off", int'(ob_eject), 0);
            end
        end
        change_valid = 1'b1;
        coin_ack = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        change_valid = 1'b0;
        coin_ack = 1'b0;
        chk("flt_sticky", int'(ob_fault), 1);
        chk("flt_ready", int'(ob_ready), 0);
        chk("flt_busy", int'(ob_busy), 0);
        chk("flt_eject2", int'(ob_eject), 0);
        chk("flt_done", int'(ob_done), 0);
        rst = 1'b0;
        #1;
        chk("flt_clear", int'(ob_fault), 0);
        chk("flt_clear_ready", int'(ob_ready), 1);
        @(negedge clock);
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
